exu: RTL and testbench
======================

# exu

Execute stage directly downstream of the instruction fetch unit. It accepts one `pc`/`instr` pair per valid/ready handshake and executes the RV32I subset: OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, word LW/SW, ECALL/EBREAK. It owns the 32x32 register file, drives the data RAM port, and reports retirement, control-flow redirects and halt.

## Interface
Parameters:
- `RST_PC`, 32'h80000000: reset PC; informational only, used by `retire_pc` checkers.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_valid`  in  1  fetch has an instruction
- `i_ready`  out  1  exu can accept this cycle
- `i_pc`  in  32  instruction address
- `i_instr`  in  32  instruction word
- `exu2ram_cs`  out  1  data RAM select
- `exu2ram_w_en`  out  1  data RAM write enable
- `exu2ram_addr`  out  15  word index, byte address bits [16:2]
- `exu2ram_dout`  out  32  store data
- `exu2ram_din`  in  32  load data, valid the cycle after `cs` (synchronous read)
- `retire_valid`  out  1  one-cycle pulse per retired instruction
- `retire_pc`  out  32  PC of the retired instruction
- `redirect_valid`  out  1  one-cycle pulse: next PC is not pc+4
- `redirect_pc`  out  32  redirect target
- `halt`  out  1  sticky stop indication

## Operation
- FSM states: IDLE, LD_WAIT, HALT. Reset state is IDLE.
- `i_ready` = (state == IDLE). Accept = `i_valid & i_ready`.
- IDLE with accept, non-load: result is computed combinationally from `i_instr` and register reads. `rd` is written at the clock edge. x0 writes are discarded and x0 always reads 0. State stays IDLE.
- Load accept (funct3=010): `cs`=1, `w_en`=0, `addr`=(rs1+imm)[16:2] in the accept cycle. Next state is LD_WAIT with `rd` and `pc` latched. In LD_WAIT, `exu2ram_din` is written to `rd`, then the FSM returns to IDLE.
- Store accept (funct3=010): `cs`=1, `w_en`=1, `addr`=(rs1+imm)[16:2], `dout`=rs2. Single cycle.
- `cs`/`w_en` are 0 in every other cycle.
- ALU: add, sub, sll, slt, sltu, xor, srl, sra, or, and. Shift amount is the low 5 bits. All arithmetic is 32-bit wrap-around with no overflow detection.
- JAL: rd=pc+4, target=pc+J-imm. JALR: rd=pc+4, target=(rs1+I-imm)&~1. BRANCH (beq/bne/blt/bge/bltu/bgeu): target=pc+B-imm, taken only if the condition holds. A not-taken branch produces no redirect.
- HALT is entered on accept of any of:
  - ECALL/EBREAK;
  - an unsupported opcode or funct3 (including non-word loads/stores);
  - a load/store address with bits[1:0]≠0;
  - a taken target with bit1≠0.
- On a halting instruction: no register write, no RAM access, no retire, no redirect.
- In HALT: `halt`=1, `i_ready`=0, until reset.
- Reset mid-operation (any state): state→IDLE, all registers→0, pending load discarded, all pulses cleared.

## Timing
- Reset values: `i_ready`=1, `exu2ram_cs`=0, `w_en`=0, `addr`=0, `dout`=0, `retire_valid`=0, `retire_pc`=0, `redirect_valid`=0, `redirect_pc`=0, `halt`=0, regfile all 0.
- `i_ready` and the RAM port are combinational from state and inputs. `retire_*`, `redirect_*` and `halt` are registered.
- Non-load: `retire_valid` pulses in the cycle after accept. Throughput is 1 per cycle.
- Load: `retire_valid` pulses in the cycle after LD_WAIT (2 cycles after accept). `i_ready`=0 during LD_WAIT. Throughput is 1 per 2 cycles.
- `redirect_valid` pulses in the same cycle as the matching `retire_valid`.
- A register written at edge N is visible to an instruction accepted in the cycle after edge N. No bypass is needed beyond the regfile's same-edge write-then-read ordering.
- `i_valid` without `i_ready` is held by fetch. exu samples nothing unless accept occurs.

## Test plan
- Reset, then `addi x1,x0,5` ; `addi x2,x1,-7` back-to-back -> retire pulses on consecutive cycles. x1=5, x2=0xFFFFFFFE. `i_ready` stays 1.
- `sw x2,8(x0)` then `lw x3,8(x0)` -> store cycle shows cs=1, w_en=1, addr=2, dout=0xFFFFFFFE. Load holds `i_ready`=0 for 1 cycle. x3=0xFFFFFFFE. Load retire occurs 2 cycles after accept.
- `beq x0,x0,+16` at pc 0x80000010 -> redirect_valid=1, redirect_pc=0x80000020. `bne x0,x0,+16` -> no redirect, retire only.
- `jalr x5,3(x1)` with x1=0x80000101 -> x5=pc+4, redirect_pc=0x80000104 (bit0 cleared).
- `lw x4,2(x0)` (misaligned) -> halt=1 next cycle, no RAM access, no retire. `i_ready`=0 thereafter. `i_valid` held high is never accepted.
- Assert rst_n low during LD_WAIT -> outputs return to reset values immediately. The target register is not written. After release, `i_ready`=1.

Source files
------------

// File: rtl/exu_if.sv
// Fetch-to-execute handshake plus the data RAM port of the execute stage.
// The master side is fetch together with the RAM; the slave side is exu.
interface exu_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_pc;
    logic [31:0] i_instr;
    logic        exu2ram_cs;
    logic        exu2ram_w_en;
    logic [14:0] exu2ram_addr;
    logic [31:0] exu2ram_dout;
    logic [31:0] exu2ram_din;

    modport master (
        output i_valid, i_pc, i_instr, exu2ram_din,
        input  i_ready, exu2ram_cs, exu2ram_w_en, exu2ram_addr, exu2ram_dout
    );

    modport slave (
        input  i_valid, i_pc, i_instr, exu2ram_din,
        output i_ready, exu2ram_cs, exu2ram_w_en, exu2ram_addr, exu2ram_dout
    );
endinterface

// File: rtl/exu.sv
// RV32I execute stage: register file, ALU, branch/jump resolution and word load/store.
// Loads take two cycles; any illegal or misaligned instruction parks the stage in HALT.
module exu #(
    parameter logic [31:0] RST_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    exu_if.slave        bus,
    output logic        retire_valid,
    output logic [31:0] retire_pc,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        halt
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_LD_WAIT, S_HALT} state_e;

    state_e      r_state, w_state_nxt;
    logic [31:0] r_regs [32];
    logic [4:0]  r_ld_rd;
    logic [31:0] r_ld_pc;
    logic        r_retire_valid, r_redirect_valid, r_halt;
    logic [31:0] r_retire_pc, r_redirect_pc;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_rs1_val, w_rs2_val;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_mem_addr;
    logic        w_wb_en, w_is_load, w_is_store, w_taken, w_bad;
    logic [31:0] w_wb_data, w_target;
    logic        w_accept, w_go;
    logic        w_unused_bits;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        case (f3)
            3'd0:    y = alt ? a - b : a + b;
            3'd1:    y = a << b[4:0];
            3'd2:    y = {31'b0, $signed(a) < $signed(b)};
            3'd3:    y = {31'b0, a < b};
            3'd4:    y = a ^ b;
            3'd5:    y = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    y = a | b;
            default: y = a & b;
        endcase
        return y;
    endfunction

    assign w_opcode  = bus.i_instr[6:0];
    assign w_rd      = bus.i_instr[11:7];
    assign w_f3      = bus.i_instr[14:12];
    assign w_rs1     = bus.i_instr[19:15];
    assign w_rs2     = bus.i_instr[24:20];
    assign w_rs1_val = r_regs[w_rs1];
    assign w_rs2_val = r_regs[w_rs2];

    assign w_imm_i = {{20{bus.i_instr[31]}}, bus.i_instr[31:20]};
    assign w_imm_s = {{20{bus.i_instr[31]}}, bus.i_instr[31:25], bus.i_instr[11:7]};
    assign w_imm_b = {{19{bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[7],
                      bus.i_instr[30:25], bus.i_instr[11:8], 1'b0};
    assign w_imm_u = {bus.i_instr[31:12], 12'b0};
    assign w_imm_j = {{11{bus.i_instr[31]}}, bus.i_instr[31], bus.i_instr[19:12],
                      bus.i_instr[20], bus.i_instr[30:21], 1'b0};

    assign w_mem_addr    = w_rs1_val + ((w_opcode == OPC_STORE) ? w_imm_s : w_imm_i);
    assign w_unused_bits = ^{w_mem_addr[31:17], RST_PC};

    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    always_comb begin
        w_wb_en    = 1'b0;
        w_wb_data  = '0;
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_taken    = 1'b0;
        w_target   = '0;
        w_bad      = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_wb_en   = 1'b1;
                w_wb_data = alu(w_f3, bus.i_instr[30], w_rs1_val, w_rs2_val);
            end
            OPC_IMM: begin
                w_wb_en   = 1'b1;
                w_wb_data = alu(w_f3, (w_f3 == 3'd5) & bus.i_instr[30], w_rs1_val, w_imm_i);
            end
            OPC_LUI: begin
                w_wb_en   = 1'b1;
                w_wb_data = w_imm_u;
            end
            OPC_AUIPC: begin
                w_wb_en   = 1'b1;
                w_wb_data = bus.i_pc + w_imm_u;
            end
            OPC_JAL: begin
                w_wb_en   = 1'b1;
                w_wb_data = bus.i_pc + 32'd4;
                w_taken   = 1'b1;
                w_target  = bus.i_pc + w_imm_j;
            end
            OPC_JALR: begin
                w_wb_en   = 1'b1;
                w_wb_data = bus.i_pc + 32'd4;
                w_taken   = 1'b1;
                w_target  = (w_rs1_val + w_imm_i) & ~32'd1;
                w_bad     = (w_f3 != 3'd0);
            end
            OPC_BRANCH: begin
                w_target = bus.i_pc + w_imm_b;
                case (w_f3)
                    3'd0:    w_taken = (w_rs1_val == w_rs2_val);
                    3'd1:    w_taken = (w_rs1_val != w_rs2_val);
                    3'd4:    w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
                    3'd5:    w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
                    3'd6:    w_taken = (w_rs1_val <  w_rs2_val);
                    3'd7:    w_taken = (w_rs1_val >= w_rs2_val);
                    default: w_bad   = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_is_load = 1'b1;
                w_bad     = (w_f3 != 3'd2) || (w_mem_addr[1:0] != 2'd0);
            end
            OPC_STORE: begin
                w_is_store = 1'b1;
                w_bad      = (w_f3 != 3'd2) || (w_mem_addr[1:0] != 2'd0);
            end
            default: w_bad = 1'b1;
        endcase
        if (w_taken && w_target[1])
            w_bad = 1'b1;
    end

    assign bus.i_ready      = (r_state == S_IDLE);
    assign w_accept         = bus.i_valid & bus.i_ready;
    assign w_go             = w_accept & ~w_bad;
    assign bus.exu2ram_cs   = w_go & (w_is_load | w_is_store);
    assign bus.exu2ram_w_en = w_go & w_is_store;
    assign bus.exu2ram_addr = bus.exu2ram_cs ? w_mem_addr[16:2] : '0;
    assign bus.exu2ram_dout = bus.exu2ram_w_en ? w_rs2_val : '0;

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_bad)          w_state_nxt = S_HALT;
                else if (w_accept && w_is_load) w_state_nxt = S_LD_WAIT;
            end
            S_LD_WAIT: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_valid   <= 1'b0;
            r_retire_pc      <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_halt           <= 1'b0;
            r_ld_rd          <= '0;
            r_ld_pc          <= '0;
        end else begin
            r_retire_valid   <= 1'b0;
            r_redirect_valid <= 1'b0;
            if (w_go && !w_is_load) begin
                r_retire_valid   <= 1'b1;
                r_retire_pc      <= bus.i_pc;
                r_redirect_valid <= w_taken;
                if (w_taken) r_redirect_pc <= w_target;
            end
            if (w_go && w_is_load) begin
                r_ld_rd <= w_rd;
                r_ld_pc <= bus.i_pc;
            end
            if (r_state == S_LD_WAIT) begin
                r_retire_valid <= 1'b1;
                r_retire_pc    <= r_ld_pc;
            end
            if (w_accept && w_bad) r_halt <= 1'b1;
        end
    end

    // NOTE: the register file is cleared by reset because all-zero registers are part of the reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_go && w_wb_en && (w_rd != 5'd0)) begin
            r_regs[w_rd] <= w_wb_data;
        end else if ((r_state == S_LD_WAIT) && (r_ld_rd != 5'd0)) begin
            r_regs[r_ld_rd] <= bus.exu2ram_din;
        end
    end

    assign retire_valid   = r_retire_valid;
    assign retire_pc      = r_retire_pc;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign halt           = r_halt;
endmodule

// File: tb/tb_exu.sv
// Randomized scoreboard bench for exu: an instruction-level model predicts retires and RAM
// accesses, and a monitor compares them against what the DUT presents.
module tb_exu;
    typedef enum {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_LW, OP_SW
    } op_e;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        redir;
        logic [31:0] tgt;
    } ret_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [14:0] addr;
        logic [31:0] dout;
    } ram_t;

    typedef struct {
        logic        wb;
        logic [31:0] wdata;
        logic        ld;
        logic        st;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        taken;
        logic [31:0] tgt;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        retire_valid, redirect_valid, halt;
    logic [31:0] retire_pc, redirect_pc;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [32768];
    logic [31:0] ram    [32768];
    logic [31:0] m_pc;
    ret_t        ret_q [$];
    ram_t        ram_q [$];

    exu_if bus ();

    exu #(.RST_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .retire_valid   (retire_valid),
        .retire_pc      (retire_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.exu2ram_cs) begin
            if (bus.exu2ram_w_en) ram[bus.exu2ram_addr] <= bus.exu2ram_dout;
            else                  bus.exu2ram_din <= ram[bus.exu2ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc(input op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
        case (op)
            OP_ADD:   return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
            OP_SUB:   return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
            OP_SLL:   return {7'h00, rs2, rs1, 3'd1, rd, 7'h33};
            OP_SLT:   return {7'h00, rs2, rs1, 3'd2, rd, 7'h33};
            OP_SLTU:  return {7'h00, rs2, rs1, 3'd3, rd, 7'h33};
            OP_XOR:   return {7'h00, rs2, rs1, 3'd4, rd, 7'h33};
            OP_SRL:   return {7'h00, rs2, rs1, 3'd5, rd, 7'h33};
            OP_SRA:   return {7'h20, rs2, rs1, 3'd5, rd, 7'h33};
            OP_OR:    return {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
            OP_AND:   return {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
            OP_ADDI:  return {imm[11:0], rs1, 3'd0, rd, 7'h13};
            OP_SLTI:  return {imm[11:0], rs1, 3'd2, rd, 7'h13};
            OP_SLTIU: return {imm[11:0], rs1, 3'd3, rd, 7'h13};
            OP_XORI:  return {imm[11:0], rs1, 3'd4, rd, 7'h13};
            OP_ORI:   return {imm[11:0], rs1, 3'd6, rd, 7'h13};
            OP_ANDI:  return {imm[11:0], rs1, 3'd7, rd, 7'h13};
            OP_SLLI:  return {7'h00, imm[4:0], rs1, 3'd1, rd, 7'h13};
            OP_SRLI:  return {7'h00, imm[4:0], rs1, 3'd5, rd, 7'h13};
            OP_SRAI:  return {7'h20, imm[4:0], rs1, 3'd5, rd, 7'h13};
            OP_LUI:   return {imm[31:12], rd, 7'h37};
            OP_AUIPC: return {imm[31:12], rd, 7'h17};
            OP_JAL:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
            OP_JALR:  return {imm[11:0], rs1, 3'd0, rd, 7'h67};
            OP_BEQ:   return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'h63};
            OP_BNE:   return {imm[12], imm[10:5], rs2, rs1, 3'd1, imm[4:1], imm[11], 7'h63};
            OP_BLT:   return {imm[12], imm[10:5], rs2, rs1, 3'd4, imm[4:1], imm[11], 7'h63};
            OP_BGE:   return {imm[12], imm[10:5], rs2, rs1, 3'd5, imm[4:1], imm[11], 7'h63};
            OP_BLTU:  return {imm[12], imm[10:5], rs2, rs1, 3'd6, imm[4:1], imm[11], 7'h63};
            OP_BGEU:  return {imm[12], imm[10:5], rs2, rs1, 3'd7, imm[4:1], imm[11], 7'h63};
            OP_LW:    return {imm[11:0], rs1, 3'd2, rd, 7'h03};
            OP_SW:    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
            default:  return 32'h0;
        endcase
    endfunction

    // Instruction semantics straight from the ISA rules, on model registers and memory.
    function automatic res_t model(input op_e op, input int rs1, input int rs2, input logic [31:0] imm);
        res_t r;
        logic [31:0] a, b;
        a = m_regs[rs1];
        b = m_regs[rs2];
        r = '{wb: 1'b1, wdata: 32'h0, ld: 1'b0, st: 1'b0, addr: 32'h0, sdata: 32'h0, taken: 1'b0, tgt: 32'h0};
        case (op)
            OP_ADD:   r.wdata = a + b;
            OP_SUB:   r.wdata = a - b;
            OP_SLL:   r.wdata = a << b[4:0];
            OP_SLT:   r.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:  r.wdata = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:   r.wdata = a ^ b;
            OP_SRL:   r.wdata = a >> b[4:0];
            OP_SRA:   r.wdata = 32'($signed(a) >>> b[4:0]);
            OP_OR:    r.wdata = a | b;
            OP_AND:   r.wdata = a & b;
            OP_ADDI:  r.wdata = a + imm;
            OP_SLTI:  r.wdata = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_SLTIU: r.wdata = (a < imm) ? 32'd1 : 32'd0;
            OP_XORI:  r.wdata = a ^ imm;
            OP_ORI:   r.wdata = a | imm;
            OP_ANDI:  r.wdata = a & imm;
            OP_SLLI:  r.wdata = a << imm[4:0];
            OP_SRLI:  r.wdata = a >> imm[4:0];
            OP_SRAI:  r.wdata = 32'($signed(a) >>> imm[4:0]);
            OP_LUI:   r.wdata = imm;
            OP_AUIPC: r.wdata = m_pc + imm;
            OP_JAL:   begin r.wdata = m_pc + 4; r.taken = 1'b1; r.tgt = m_pc + imm; end
            OP_JALR:  begin r.wdata = m_pc + 4; r.taken = 1'b1; r.tgt = (a + imm) & ~32'd1; end
            OP_LW:    begin r.wb = 1'b0; r.ld = 1'b1; r.addr = a + imm; r.wdata = m_mem[r.addr[16:2]]; end
            OP_SW:    begin r.wb = 1'b0; r.st = 1'b1; r.addr = a + imm; r.sdata = b; end
            default: begin
                r.wb    = 1'b0;
                r.tgt   = m_pc + imm;
                r.taken = (op == OP_BEQ)  ? (a == b) :
                          (op == OP_BNE)  ? (a != b) :
                          (op == OP_BLT)  ? ($signed(a) <  $signed(b)) :
                          (op == OP_BGE)  ? ($signed(a) >= $signed(b)) :
                          (op == OP_BLTU) ? (a <  b) : (a >= b);
            end
        endcase
        return r;
    endfunction

    task automatic issue(input op_e op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
        res_t r;
        ret_t e;
        ram_t m;
        int   w;
        r = model(op, rs1, rs2, imm);
        bus.i_valid = 1'b1;
        bus.i_pc    = m_pc;
        bus.i_instr = enc(op, 5'(rd), 5'(rs1), 5'(rs2), imm);
        w = 0;
        while (!bus.i_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!bus.i_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.i_valid = 1'b0;
            return;
        end
        e.cyc   = cyc + (r.ld ? 2 : 1);
        e.pc    = m_pc;
        e.redir = r.taken;
        e.tgt   = r.tgt;
        ret_q.push_back(e);
        if (r.ld || r.st) begin
            m.cyc  = cyc;
            m.we   = r.st;
            m.addr = r.addr[16:2];
            m.dout = r.sdata;
            ram_q.push_back(m);
        end
        if (r.st) m_mem[r.addr[16:2]] = r.sdata;
        if ((r.wb || r.ld) && rd != 0) m_regs[rd] = r.wdata;
        m_pc = r.taken ? r.tgt : m_pc + 32'd4;
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a retire or a RAM access.
    initial begin : monitor
        ret_t e;
        ram_t m;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (retire_valid) begin
                    if (ret_q.size() == 0) check("retire_unexpected", 32'd1, 32'd0);
                    else begin
                        e = ret_q.pop_front();
                        check("retire_cycle", 32'(cyc), 32'(e.cyc));
                        check("retire_pc", retire_pc, e.pc);
                        check("redirect_valid", {31'b0, redirect_valid}, {31'b0, e.redir});
                        if (e.redir) check("redirect_pc", redirect_pc, e.tgt);
                    end
                end else begin
                    if (redirect_valid) check("redirect_orphan", 32'd1, 32'd0);
                    if (ret_q.size() > 0 && ret_q[0].cyc < cyc) begin
                        e = ret_q.pop_front();
                        check("retire_missing", 32'd0, e.pc);
                    end
                end
                if (bus.exu2ram_cs) begin
                    if (ram_q.size() == 0) check("ram_unexpected", 32'd1, 32'd0);
                    else begin
                        m = ram_q.pop_front();
                        check("ram_cycle", 32'(cyc), 32'(m.cyc));
                        check("ram_w_en", {31'b0, bus.exu2ram_w_en}, {31'b0, m.we});
                        check("ram_addr", {17'b0, bus.exu2ram_addr}, {17'b0, m.addr});
                        if (m.we) check("ram_dout", bus.exu2ram_dout, m.dout);
                    end
                end else if (ram_q.size() > 0 && ram_q[0].cyc < cyc) begin
                    m = ram_q.pop_front();
                    check("ram_missing", 32'd0, 32'd1);
                end
            end
        end
    end

    initial begin : stimulus
        op_e         op;
        int          off;
        logic [31:0] imm;
        for (int i = 0; i < 32768; i++) begin
            m_mem[i] = '0;
            ram[i]   = '0;
        end
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        bus.i_valid = 1'b0;
        bus.i_pc    = '0;
        bus.i_instr = '0;
        m_pc        = 32'h8000_0000;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_i_ready", {31'b0, bus.i_ready}, 32'd1);
        check("rst_cs", {31'b0, bus.exu2ram_cs}, 32'd0);
        check("rst_w_en", {31'b0, bus.exu2ram_w_en}, 32'd0);
        check("rst_addr", {17'b0, bus.exu2ram_addr}, 32'd0);
        check("rst_dout", bus.exu2ram_dout, 32'd0);
        check("rst_retire_valid", {31'b0, retire_valid}, 32'd0);
        check("rst_retire_pc", retire_pc, 32'd0);
        check("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_halt", {31'b0, halt}, 32'd0);
        @(negedge clk);

        // Directed sequence: ALU chain, store/load round trip, branches, jalr.
        issue(OP_ADDI, 1, 0, 0, 32'd5);
        issue(OP_ADDI, 2, 1, 0, 32'hFFFF_FFF9);
        issue(OP_SW,   0, 0, 2, 32'd8);
        issue(OP_LW,   3, 0, 0, 32'd8);
        issue(OP_BEQ,  0, 0, 0, 32'd16);
        issue(OP_BNE,  0, 0, 0, 32'd16);
        issue(OP_SW,   0, 0, 3, 32'd12);
        issue(OP_LUI,  1, 0, 0, 32'h8000_0000);
        issue(OP_ADDI, 1, 1, 0, 32'h101);
        issue(OP_JALR, 5, 1, 0, 32'd3);
        issue(OP_SW,   0, 0, 5, 32'd16);

        for (int n = 0; n < 300; n++) begin
            op = op_e'($urandom_range(0, 30));
            if (op == OP_JALR) op = OP_ADD;
            imm = $urandom();
            imm = {{20{imm[11]}}, imm[11:0]};
            if (op == OP_LUI || op == OP_AUIPC) imm = imm & 32'hFFFF_F000;
            if (op == OP_JAL || (op >= OP_BEQ && op <= OP_BGEU)) begin
                off = 4 * $urandom_range(0, 31) - 64;
                if (off == 4) off = 8;
                imm = 32'(off);
            end
            if (op == OP_LW || op == OP_SW)
                issue(op, $urandom_range(0, 31), 0, $urandom_range(0, 31), 32'(4 * $urandom_range(0, 63)));
            else
                issue(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm);
        end
        for (int k = 1; k < 32; k++) issue(OP_SW, 0, 0, k, 32'(32'h400 + 4 * k));
        bus.i_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("drain_retire", 32'(ret_q.size()), 32'd0);
        check("drain_ram", 32'(ram_q.size()), 32'd0);

        // Misaligned load halts the stage and is held off forever.
        bus.i_valid = 1'b1;
        bus.i_pc    = m_pc;
        bus.i_instr = enc(OP_LW, 5'd4, 5'd0, 5'd0, 32'd2);
        #1;
        check("halt_no_cs", {31'b0, bus.exu2ram_cs}, 32'd0);
        @(negedge clk);
        #1;
        check("halt_set", {31'b0, halt}, 32'd1);
        check("halt_not_ready", {31'b0, bus.i_ready}, 32'd0);
        check("halt_no_retire", {31'b0, retire_valid}, 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check("halt_sticky", {31'b0, halt}, 32'd1);
        check("halt_still_not_ready", {31'b0, bus.i_ready}, 32'd0);
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_clears_halt", {31'b0, halt}, 32'd0);
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h8000_0000;
        @(negedge clk);

        // Reset while a load is outstanding: the target register must stay at zero.
        issue(OP_ADDI, 7, 0, 0, 32'h55);
        issue(OP_SW,   0, 0, 7, 32'd16);
        bus.i_valid = 1'b1;
        bus.i_pc    = m_pc;
        bus.i_instr = enc(OP_LW, 5'd6, 5'd0, 5'd0, 32'd16);
        ram_q.push_back('{cyc: cyc, we: 1'b0, addr: 15'd4, dout: 32'd0});
        @(negedge clk);
        bus.i_valid = 1'b0;
        #1;
        check("ldwait_not_ready", {31'b0, bus.i_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("ldrst_i_ready", {31'b0, bus.i_ready}, 32'd1);
        check("ldrst_cs", {31'b0, bus.exu2ram_cs}, 32'd0);
        check("ldrst_retire_valid", {31'b0, retire_valid}, 32'd0);
        check("ldrst_retire_pc", retire_pc, 32'd0);
        check("ldrst_redirect_pc", redirect_pc, 32'd0);
        check("ldrst_halt", {31'b0, halt}, 32'd0);
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h8000_0000;
        #1;
        check("ldrst_ready_after", {31'b0, bus.i_ready}, 32'd1);
        @(negedge clk);
        issue(OP_SW, 0, 0, 6, 32'd20);
        issue(OP_SW, 0, 0, 7, 32'd24);
        bus.i_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("final_drain_retire", 32'(ret_q.size()), 32'd0);
        check("final_drain_ram", 32'(ram_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
